draw_scheduler: RTL and testbench
=================================

// Module: draw_scheduler
// PURPOSE
//  Owns the single VGA framebuffer write port and sequences all sprite drawers (clear, platform,
//  ball, bricks) once per frame. Generates the frame tick, pulses each enabled client's draw
//  start in fixed slot order, muxes the active client's x/y/colour/wren to the VGA adapter, then
//  issues a one-cycle move_en so game objects update only after the frame is fully drawn.
// PARAMETERS
//  NREQ          4        number of client slots; slot 0 drawn first, NREQ-1 last
//  FRAME_CYCLES  833334   clk cycles per frame (50 MHz / 60 Hz); must be >= 2
//  WAIT_MAX      4096     max cycles a client may hold the port before forced advance
// PORTS
//  clk           in   1         clock
//  resetn        in   1         synchronous, active-low reset
//  en_mask       in   NREQ      1 = slot participates this frame (sampled at frame tick)
//  cl_done       in   NREQ      client finished its draw (level or pulse, sampled in WAIT)
//  cl_x          in   NREQ*10   client x, slot i at [10i+9:10i]
//  cl_y          in   NREQ*10   client y, same packing
//  cl_colour     in   NREQ*3    client colour, slot i at [3i+2:3i]
//  cl_wren       in   NREQ      client write enable
//  cl_draw       out  NREQ      one-cycle start pulse to slot i
//  vga_x         out  10        muxed x to VGA adapter
//  vga_y         out  10        muxed y
//  vga_colour    out  3         muxed colour
//  vga_wren      out  1         muxed write enable
//  move_en       out  1         one-cycle pulse: all slots done, objects may move
//  busy          out  1         high from frame tick accept to move_en (inclusive)
//  overrun       out  1         sticky: frame tick arrived while busy
//  timeout       out  1         sticky: some slot hit WAIT_MAX
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, frame counter 0, slot index 0, latched mask 0.
//  Frame timer: counts 0..FRAME_CYCLES-1, tick is a 1-cycle pulse on the wrap cycle; free-running.
//  FSM states: IDLE, START, WAIT, NEXT, MOVE.
//   IDLE  : on tick -> latch en_mask, slot=0, -> NEXT-check via START/NEXT rule below.
//   START : if mask[slot]: cl_draw[slot]=1 one cycle, clear wait counter, -> WAIT;
//           else -> NEXT (skipped slot costs exactly 1 cycle, no draw pulse).
//   WAIT  : mux slot's x/y/colour/wren to vga_*; on cl_done[slot] or wait==WAIT_MAX-1 -> NEXT;
//           timeout path sets timeout sticky.
//   NEXT  : if slot==NREQ-1 -> MOVE, else slot+1 -> START.
//   MOVE  : move_en=1 one cycle -> IDLE.
//  Outside WAIT: vga_wren=0, vga_x/y/colour=0. In WAIT wren passes combinationally (0 latency).
//  cl_done is ignored in START (same cycle as draw pulse); earliest honoured done is WAIT cycle 1.
//  Tick while busy: dropped (no queueing), overrun set; sticky bits clear only on reset.
//  Tick and MOVE in same cycle: counts as busy -> overrun, tick dropped.
//  en_mask all zero: tick -> NREQ START/NEXT pairs, then move_en; vga_wren never asserted.
//  en_mask changes mid-frame: no effect until next accepted tick.
//  Reset mid-frame: immediate return to IDLE; no draw or move_en pulse emitted afterwards.
//  Widths: wait counter $clog2(WAIT_MAX) bits, frame counter $clog2(FRAME_CYCLES) bits; no wrap
//  beyond terminal values.
// STRUCTURE
//  Shared defines header (with PLATSIZE/PLATY): COORD_W=10, COLOUR_W=3, slot ids SLOT_CLEAR=0,
//  SLOT_PLAT=1, SLOT_BALL=2, SLOT_BRICK=3, FSM state encodings.
//  Sub-module frame_timer (clk, resetn, tick) holding the frame counter; FSM + mux in top.
// TESTING
//  1 FRAME_CYCLES=200, mask=4'b1111, each client asserts done 5 cycles after draw -> draws pulse in
//    order 0,1,2,3; move_en once per frame; busy spans tick..move_en; no overrun.
//  2 mask=4'b0101 -> cl_draw only on slots 0,2; slots 1,3 each cost 1 cycle; vga_wren only from 0,2.
//  3 slot 1 never asserts done, WAIT_MAX=16 -> slot 1 owns port exactly 16 cycles, timeout=1,
//    slots 2,3 still drawn, move_en still issued.
//  4 FRAME_CYCLES=20, clients take 10 cycles each -> second tick dropped, overrun=1, next
//    accepted tick starts clean at slot 0.
//  5 resetn low for 1 cycle while slot 2 in WAIT -> all outputs 0 next cycle, no move_en, next
//    tick restarts at slot 0.
//  6 client drives cl_wren=1, x=37,y=110,colour=3'b100 during its WAIT -> vga_* identical same
//    cycle; other slots' nonzero cl_wren never reach vga_wren.

Source files
------------

// File: rtl/draw_scheduler_pkg.sv
// Shared definitions for the frame draw scheduler: bus widths, client slot
// assignments, playfield constants and FSM state encodings.
package draw_scheduler_pkg;

  localparam int COORD_W  = 10;
  localparam int COLOUR_W = 3;

  localparam int PLATSIZE = 40;
  localparam int PLATY    = 440;

  localparam int SLOT_CLEAR = 0;
  localparam int SLOT_PLAT  = 1;
  localparam int SLOT_BALL  = 2;
  localparam int SLOT_BRICK = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_MOVE  = 3'd4
  } state_e;

endpackage

// File: rtl/draw_scheduler_frame_timer.sv
// Free-running frame counter; tick is high for the single cycle in which the
// counter sits at its terminal value, i.e. the cycle before it wraps to 0.
module draw_scheduler_frame_timer #(
  parameter int FRAME_CYCLES = 833334
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d gets its default before the wrap override, so every path
  // assigns it and no latch can be inferred.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CNT_LAST) cnt_d = '0;
  end

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/draw_scheduler.sv
// Frame draw scheduler: owns the single framebuffer write port, starts each
// enabled drawer in slot order once per frame, then pulses move_en.
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int FRAME_CYCLES = 833334,
  parameter int WAIT_MAX     = 4096
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NREQ-1:0]              en_mask,
  input  logic [NREQ-1:0]              cl_done,
  input  logic [NREQ*COORD_W-1:0]      cl_x,
  input  logic [NREQ*COORD_W-1:0]      cl_y,
  input  logic [NREQ*COLOUR_W-1:0]     cl_colour,
  input  logic [NREQ-1:0]              cl_wren,
  output logic [NREQ-1:0]              cl_draw,
  output logic [COORD_W-1:0]           vga_x,
  output logic [COORD_W-1:0]           vga_y,
  output logic [COLOUR_W-1:0]          vga_colour,
  output logic                         vga_wren,
  output logic                         move_en,
  output logic                         busy,
  output logic                         overrun,
  output logic                         timeout
);

  localparam int SLOT_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NREQ - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  logic tick;

  draw_scheduler_frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_frame_timer (
    .clk    (clk),
    .resetn (resetn),
    .tick   (tick)
  );

  // Unpack the flat client buses so the mux below indexes by slot directly.
  logic [COORD_W-1:0]  x_arr [NREQ];
  logic [COORD_W-1:0]  y_arr [NREQ];
  logic [COLOUR_W-1:0] c_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign x_arr[i] = cl_x[i*COORD_W +: COORD_W];
    assign y_arr[i] = cl_y[i*COORD_W +: COORD_W];
    assign c_arr[i] = cl_colour[i*COLOUR_W +: COLOUR_W];
  end

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [NREQ-1:0]   mask_q, mask_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    wait_d     = wait_q;
    mask_d     = mask_q;
    overrun_d  = overrun_q;
    timeout_d  = timeout_q;
    cl_draw    = '0;
    move_en    = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_wren   = 1'b0;

    // A tick that lands in any non-idle state, MOVE included, is dropped.
    if (tick && (state_q != ST_IDLE)) overrun_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          mask_d  = en_mask;
          slot_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (mask_q[slot_q]) begin
          cl_draw[slot_q] = 1'b1;
          wait_d          = '0;
          state_d         = ST_WAIT;
        end else begin
          state_d = ST_NEXT;
        end
      end
      ST_WAIT: begin
        vga_x      = x_arr[slot_q];
        vga_y      = y_arr[slot_q];
        vga_colour = c_arr[slot_q];
        vga_wren   = cl_wren[slot_q];
        if (cl_done[slot_q]) begin
          state_d = ST_NEXT;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_NEXT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_NEXT: begin
        if (slot_q == SLOT_LAST) begin
          state_d = ST_MOVE;
        end else begin
          slot_d  = slot_q + 1'b1;
          state_d = ST_START;
        end
      end
      ST_MOVE: begin
        move_en = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      slot_q    <= '0;
      wait_q    <= '0;
      mask_q    <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      wait_q    <= wait_d;
      mask_q    <= mask_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign overrun = overrun_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: stimulus queues expected draw/move
// events per frame, a monitor pops and compares them as the DUT emits them.
`timescale 1ns/1ps
module tb_draw_scheduler;
  import draw_scheduler_pkg::*;

  localparam int NREQ = 4;
  localparam int F    = 50;
  localparam int WMAX = 16;

  logic                     clk = 1'b0;
  logic                     resetn = 1'b0;
  logic [NREQ-1:0]          en_mask = '0;
  logic [NREQ-1:0]          cl_done = '0;
  logic [NREQ-1:0]          cl_wren = '0;
  logic [NREQ*COORD_W-1:0]  cl_x;
  logic [NREQ*COORD_W-1:0]  cl_y;
  logic [NREQ*COLOUR_W-1:0] cl_colour;
  logic [NREQ-1:0]          cl_draw;
  logic [COORD_W-1:0]       vga_x, vga_y;
  logic [COLOUR_W-1:0]      vga_colour;
  logic                     vga_wren, move_en, busy, overrun, timeout;

  always #5 clk = ~clk;

  draw_scheduler #(.NREQ(NREQ), .FRAME_CYCLES(F), .WAIT_MAX(WMAX)) dut (
    .clk(clk), .resetn(resetn), .en_mask(en_mask), .cl_done(cl_done),
    .cl_x(cl_x), .cl_y(cl_y), .cl_colour(cl_colour), .cl_wren(cl_wren),
    .cl_draw(cl_draw), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_wren(vga_wren), .move_en(move_en), .busy(busy),
    .overrun(overrun), .timeout(timeout)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Client constants; slot 2 carries the x=37 y=110 colour=100 pattern.
  logic [COORD_W-1:0]  cx [NREQ] = '{10'd5, 10'd600, 10'd37, 10'd1023};
  logic [COORD_W-1:0]  cy [NREQ] = '{10'd6, 10'd300, 10'd110, 10'd479};
  logic [COLOUR_W-1:0] cc [NREQ] = '{3'd1, 3'd2, 3'b100, 3'd7};

  // >0: done pulse that many cycles after draw; 0: never done; <0: done held high.
  int delay_cfg [NREQ];

  function automatic int slot_len(input int d);
    if (d > 0) return d;
    if (d == 0) return WMAX;
    return 1;
  endfunction

  typedef struct { bit is_move; int slot; int off; } ev_t;
  ev_t exp_q[$];

  int n = 0;
  int moves_seen = 0;
  int last_move_off = -1;

  always @(posedge clk) begin
    if (!resetn) n = 0;
    else         n = n + 1;
  end

  // Client models: react to draw pulses, hold constant coordinates,
  // and drive a rotating, always-nonzero write-enable pattern.
  int cnt [NREQ];
  logic [NREQ-1:0] wren_pat = 4'b1011;

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      cl_x[i*COORD_W +: COORD_W]        = cx[i];
      cl_y[i*COORD_W +: COORD_W]        = cy[i];
      cl_colour[i*COLOUR_W +: COLOUR_W] = cc[i];
    end
  end

  always @(negedge clk) begin
    wren_pat = {wren_pat[NREQ-2:0], wren_pat[NREQ-1]};
    cl_wren  = wren_pat;
    for (int i = 0; i < NREQ; i++) begin
      if (n == 0) begin
        cnt[i] = 0; cl_done[i] = 1'b0;
      end else if (cl_draw[i]) begin
        cnt[i] = delay_cfg[i]; cl_done[i] = 1'b0;
      end else if (cnt[i] > 0) begin
        cnt[i]     = cnt[i] - 1;
        cl_done[i] = (cnt[i] == 0);
      end else begin
        cl_done[i] = 1'b0;
      end
      if (delay_cfg[i] < 0) cl_done[i] = 1'b1;
    end
  end

  // Monitor: event scoreboard plus per-cycle check of the VGA mux.
  int   base = 0, owner = -1, own_start = 0, own_len = 0;
  logic prev_busy = 1'b0, prev_move = 1'b0;

  always begin
    ev_t e;
    logic [23:0] exp_v;
    @(negedge clk);
    #1;
    if (n == 0) owner = -1;

    exp_v = '0;
    if (owner >= 0 && n > own_start && n <= own_start + own_len)
      exp_v = {cl_wren[owner], cx[owner], cy[owner], cc[owner]};
    check("vga_mux", {8'd0, vga_wren, vga_x, vga_y, vga_colour}, {8'd0, exp_v});

    if (busy === 1'b1 && prev_busy !== 1'b1) begin
      base = n;
      check("tick_phase", n % F, 0);
    end
    if (prev_move === 1'b1) check("busy_after_move", busy, 0);

    if (cl_draw !== '0 || move_en !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {cl_draw, move_en}, 0);
      end else begin
        e = exp_q.pop_front();
        if (e.is_move) begin
          check("move_en", move_en, 1);
          check("move_busy", busy, 1);
        end else begin
          check("draw_slot", cl_draw, 32'd1 << e.slot);
        end
        check("event_offset", n - base, e.off);
      end
      for (int i = 0; i < NREQ; i++)
        if (cl_draw[i] === 1'b1) begin
          owner = i; own_start = n; own_len = slot_len(delay_cfg[i]);
        end
      if (move_en === 1'b1) begin
        moves_seen++;
        last_move_off = n - base;
      end
    end
    prev_busy = busy;
    prev_move = move_en;
  end

  // Expected frame: START+WAIT(len)+NEXT per enabled slot, START+NEXT per skipped slot.
  task automatic push_frame(input logic [NREQ-1:0] m);
    int off = 0;
    ev_t e;
    for (int i = 0; i < NREQ; i++) begin
      if (m[i]) begin
        e.is_move = 1'b0; e.slot = i; e.off = off;
        exp_q.push_back(e);
        off += 2 + slot_len(delay_cfg[i]);
      end else begin
        off += 2;
      end
    end
    e.is_move = 1'b1; e.slot = 0; e.off = off;
    exp_q.push_back(e);
  endtask

  task automatic wait_move(input string name, input int exp_len);
    int start = moves_seen;
    int k = 0;
    while (moves_seen == start && k < 4 * F) begin
      @(negedge clk);
      k++;
    end
    check({name, "_move_seen"}, (moves_seen != start), 1);
    check({name, "_frame_len"}, last_move_off, exp_len);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_busy"},    busy, 0);
    check({name, "_draw"},    cl_draw, 0);
    check({name, "_move"},    move_en, 0);
    check({name, "_vga"},     {vga_wren, vga_x, vga_y, vga_colour}, 0);
    check({name, "_overrun"}, overrun, 0);
    check({name, "_timeout"}, timeout, 0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < NREQ; i++) delay_cfg[i] = 5;
    repeat (3) @(negedge clk);
    #2;
    check_quiet("reset");
    resetn = 1'b1;

    // Full mask, 5-cycle clients, two consecutive frames.
    en_mask = 4'b1111;
    push_frame(4'b1111);
    push_frame(4'b1111);
    wait_move("t1a", 28);
    wait_move("t1b", 28);
    check("t1_overrun", overrun, 0);
    check("t1_timeout", timeout, 0);

    // Slot 3 holds done high: ignored in START, honoured on first WAIT cycle.
    delay_cfg[3] = -1;
    push_frame(4'b1111);
    wait_move("t1c", 24);
    delay_cfg[3] = 5;

    // Sparse mask; a mid-frame mask change must not take effect.
    en_mask = 4'b0101;
    push_frame(4'b0101);
    k = 0;
    while (busy !== 1'b1 && k < 2 * F) begin @(negedge clk); k++; end
    check("t2_busy_seen", busy, 1);
    en_mask = 4'b1111;
    wait_move("t2", 18);

    // Empty mask: only START/NEXT pairs, then move_en.
    en_mask = 4'b0000;
    push_frame(4'b0000);
    wait_move("t2z", 8);

    // Slot 1 never finishes: forced advance after WMAX cycles.
    en_mask = 4'b1111;
    delay_cfg[1] = 0;
    push_frame(4'b1111);
    wait_move("t3", 39);
    check("t3_timeout", timeout, 1);
    check("t3_overrun", overrun, 0);

    // Long clients overrun the frame; the following frame restarts cleanly.
    for (int i = 0; i < NREQ; i++) delay_cfg[i] = 12;
    push_frame(4'b1111);
    wait_move("t4", 56);
    check("t4_overrun", overrun, 1);
    check("t4_timeout_sticky", timeout, 1);
    for (int i = 0; i < NREQ; i++) delay_cfg[i] = 5;
    push_frame(4'b1111);
    wait_move("t4_next", 28);

    // Reset for one cycle while slot 2 is in WAIT.
    push_frame(4'b1111);
    k = 0;
    while (cl_draw[2] !== 1'b1 && k < 2 * F) begin @(negedge clk); k++; end
    check("t5_draw2_seen", cl_draw[2], 1);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    #2;
    check_quiet("t5_after_reset");
    check("t5_pending", exp_q.size(), 2);
    exp_q.delete();
    resetn = 1'b1;
    push_frame(4'b1111);
    wait_move("t5_restart", 28);

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
